// File: rtl/pu_riscv_ahb3_port_arbiter_if.sv
// Bus bundle for the N-port AHB3-Lite arbiter: PU-side ports (s_*) and the shared system port (m_*).
// The master modport is the arbiter's view; the slave modport is the surrounding PU/system view.
interface pu_riscv_ahb3_port_arbiter_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned PLEN  = 32,
    parameter int unsigned PORTS = 2
);
    logic [PORTS-1:0]      s_HSEL;
    logic [PORTS*PLEN-1:0] s_HADDR;
    logic [PORTS*XLEN-1:0] s_HWDATA;
    logic [XLEN-1:0]       s_HRDATA;
    logic [PORTS-1:0]      s_HWRITE;
    logic [PORTS*3-1:0]    s_HSIZE;
    logic [PORTS*3-1:0]    s_HBURST;
    logic [PORTS*4-1:0]    s_HPROT;
    logic [PORTS*2-1:0]    s_HTRANS;
    logic [PORTS-1:0]      s_HMASTLOCK;
    logic [PORTS-1:0]      s_HREADY;
    logic [PORTS-1:0]      s_HRESP;

    logic                  m_HSEL;
    logic [PLEN-1:0]       m_HADDR;
    logic [XLEN-1:0]       m_HWDATA;
    logic [XLEN-1:0]       m_HRDATA;
    logic                  m_HWRITE;
    logic [2:0]            m_HSIZE;
    logic [2:0]            m_HBURST;
    logic [3:0]            m_HPROT;
    logic [1:0]            m_HTRANS;
    logic                  m_HMASTLOCK;
    logic                  m_HREADY;
    logic                  m_HRESP;

    modport master (
        input  s_HSEL, s_HADDR, s_HWDATA, s_HWRITE, s_HSIZE, s_HBURST, s_HPROT, s_HTRANS,
        input  s_HMASTLOCK,
        output s_HRDATA, s_HREADY, s_HRESP,
        output m_HSEL, m_HADDR, m_HWDATA, m_HWRITE, m_HSIZE, m_HBURST, m_HPROT, m_HTRANS,
        output m_HMASTLOCK,
        input  m_HRDATA, m_HREADY, m_HRESP
    );

    modport slave (
        output s_HSEL, s_HADDR, s_HWDATA, s_HWRITE, s_HSIZE, s_HBURST, s_HPROT, s_HTRANS,
        output s_HMASTLOCK,
        input  s_HRDATA, s_HREADY, s_HRESP,
        input  m_HSEL, m_HADDR, m_HWDATA, m_HWRITE, m_HSIZE, m_HBURST, m_HPROT, m_HTRANS,
        input  m_HMASTLOCK,
        output m_HRDATA, m_HREADY, m_HRESP
    );
endinterface

// File: rtl/pu_riscv_ahb3_port_arbiter.sv
// N-port AHB3-Lite master multiplexer with burst-aware ownership and zero-bubble handover.
// Define PU_RISCV_AHB3_ARB_RR_EN for round-robin arbitration; default is fixed lowest-index priority.
module pu_riscv_ahb3_port_arbiter #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned PLEN  = 32,
    parameter int unsigned PORTS = 2
) (
    input logic                          HCLK,
    input logic                          HRESET,
    pu_riscv_ahb3_port_arbiter_if.master bus
);
    localparam int unsigned IdxW = (PORTS > 1) ? $clog2(PORTS) : 1;

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;

    logic [PLEN-1:0] addr  [PORTS];
    logic [XLEN-1:0] wdata [PORTS];
    logic [2:0]      size  [PORTS];
    logic [2:0]      burst [PORTS];
    logic [3:0]      prot  [PORTS];
    logic [1:0]      trans [PORTS];
    logic [PORTS-1:0] req;

    for (genvar p = 0; p < PORTS; p++) begin : g_unpack
        assign addr[p]  = bus.s_HADDR[p*PLEN +: PLEN];
        assign wdata[p] = bus.s_HWDATA[p*XLEN +: XLEN];
        assign size[p]  = bus.s_HSIZE[p*3 +: 3];
        assign burst[p] = bus.s_HBURST[p*3 +: 3];
        assign prot[p]  = bus.s_HPROT[p*4 +: 4];
        assign trans[p] = bus.s_HTRANS[p*2 +: 2];
        assign req[p]   = bus.s_HSEL[p] & (trans[p] == TransNonseq);
    end

    logic [IdxW-1:0] owner_q, owner_d, downer_q, downer_d, grant;
    logic            dvalid_q, dvalid_d;
    logic [3:0]      beats_q, beats_d;
    logic            incr_lock_q, incr_lock_d;

    logic [1:0] own_trans;
    logic [2:0] own_burst;
    logic       own_lock;
    logic       accept;

    assign own_trans = trans[owner_q];
    assign own_burst = burst[owner_q];
    assign own_lock  = bus.s_HMASTLOCK[owner_q];
    assign accept    = bus.m_HREADY & own_trans[1];

`ifdef PU_RISCV_AHB3_ARB_RR_EN
    // Descending sweep so the port closest after the owner overwrites last and wins.
    always_comb begin
        grant = owner_q;
        for (int i = int'(PORTS); i >= 1; i--) begin
            if (req[(int'(owner_q) + i) % int'(PORTS)]) begin
                grant = IdxW'((int'(owner_q) + i) % int'(PORTS));
            end
        end
    end
`else
    always_comb begin
        grant = owner_q;
        for (int i = int'(PORTS) - 1; i >= 0; i--) begin
            if (req[i]) grant = IdxW'(i);
        end
    end
`endif

    always_comb begin
        owner_d     = owner_q;
        downer_d    = downer_q;
        dvalid_d    = dvalid_q;
        beats_d     = beats_q;
        incr_lock_d = incr_lock_q;
        if (bus.m_HREADY) begin
            dvalid_d = accept;
            if (accept) downer_d = owner_q;
            if (own_trans == TransIdle || own_trans == TransNonseq) incr_lock_d = 1'b0;
            if (accept && own_trans == TransNonseq) begin
                case (own_burst)
                    3'b001:         begin beats_d = 4'd0; incr_lock_d = 1'b1; end
                    3'b010, 3'b011: beats_d = 4'd3;
                    3'b100, 3'b101: beats_d = 4'd7;
                    3'b110, 3'b111: beats_d = 4'd15;
                    default:        beats_d = 4'd0;
                endcase
            end else if (accept && own_trans == TransSeq && beats_q != 4'd0) begin
                beats_d = beats_q - 4'd1;
            end
            // Handover on the last accepted beat lets the stalled port's address go out next cycle.
            if (beats_d == 4'd0 && !incr_lock_d && !own_lock && |req) owner_d = grant;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            owner_q     <= '0;
            downer_q    <= '0;
            dvalid_q    <= 1'b0;
            beats_q     <= 4'd0;
            incr_lock_q <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            downer_q    <= downer_d;
            dvalid_q    <= dvalid_d;
            beats_q     <= beats_d;
            incr_lock_q <= incr_lock_d;
        end
    end

    assign bus.m_HSEL      = ~HRESET & bus.s_HSEL[owner_q];
    assign bus.m_HADDR     = addr[owner_q];
    assign bus.m_HWDATA    = wdata[downer_q];
    assign bus.m_HWRITE    = bus.s_HWRITE[owner_q];
    assign bus.m_HSIZE     = size[owner_q];
    assign bus.m_HBURST    = own_burst;
    assign bus.m_HPROT     = prot[owner_q];
    assign bus.m_HTRANS    = HRESET ? TransIdle : own_trans;
    assign bus.m_HMASTLOCK = ~HRESET & own_lock;
    assign bus.s_HRDATA    = bus.m_HRDATA;

    always_comb begin
        bus.s_HREADY = '1;
        bus.s_HRESP  = '0;
        for (int p = 0; p < int'(PORTS); p++) begin
            if (HRESET) begin
                bus.s_HREADY[p] = 1'b1;
            end else if (owner_q == IdxW'(p) || (dvalid_q && downer_q == IdxW'(p))) begin
                bus.s_HREADY[p] = bus.m_HREADY;
            end else if (req[p]) begin
                bus.s_HREADY[p] = 1'b0;
            end
            if (!HRESET && dvalid_q && downer_q == IdxW'(p)) bus.s_HRESP[p] = bus.m_HRESP;
        end
    end
endmodule
